morph3x3_stream: RTL and testbench
==================================

# morph3x3_stream

Streaming 3x3 binary morphology filter (erosion or dilation) for raster-order grayscale pixels, with a parametrised pixel width, line width, frame height and threshold. Each input pixel is thresholded to one bit, two 1-bit line buffers build the 3x3 window, and one binary output pixel is produced per input pixel, in raster order. After the last input pixel of a frame the block flushes the pending outputs itself. It sits in the filter stage after colour conversion, in place of the fixed combinational erosion block, and uses a valid/ready handshake on both sides.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 640, pixels per line (≥3)
- IMG_H, 480, lines per frame (≥3)
- THRESH, 127, a pixel is foreground when value > THRESH (unsigned)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = erosion, 1 = dilation; sampled when the first pixel of a frame is accepted
- in_data  in  DATA_W  pixel, raster order
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  DATA_W  all-ones (foreground) or zero
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- frame_done  out  1  one-cycle pulse when the last output of a frame is accepted

## Operation
- States: RUN (accepting input), FLUSH (input complete, draining), DONE (one cycle, pulses frame_done, then back to RUN with all counters at 0).
- Counters: in_col/in_row track input position; out_col/out_row track output position; mode_q holds the latched mode.
- Step: one window advance. In RUN, a step is an input handshake (in_valid & in_ready). In FLUSH, a step occurs whenever the output slot is free; it shifts in a dummy bit.
- Thresholding: bit = (in_data > THRESH). Only bits are stored; the line buffers are 2 × IMG_W bits.
- Output for pixel (r,c) is formed when the window is centred on (r,c). This happens at the step that brings in pixel (r+1,c+1) in linear index terms, i.e. linear index k + IMG_W + 1.
- Borders: window positions outside the image (row −1/IMG_H, col −1/IMG_W) are masked to the neutral value, which is 1 for erosion and 0 for dilation. They are derived from out_row/out_col, never from stale buffer contents.
- Erosion: output = AND of the 9 masked bits. Dilation: output = OR of the 9 masked bits. out_data = {DATA_W{result}}.
- The first IMG_W+1 steps of a frame produce no output (fill). Every subsequent step produces one output.
- RUN → FLUSH when input pixel IMG_W·IMG_H−1 is accepted. FLUSH runs IMG_W+1 steps, then the last output is accepted → DONE.
- No new frame input is accepted in FLUSH or DONE; in_ready = 0 there.
- Reset mid-frame: all counters, state, mode_q and the output register clear. The next accepted pixel is treated as pixel (0,0) of a new frame. Line buffer contents are not cleared.

## Timing
- Output register: a single slot. The slot is free when !out_valid or out_ready.
- in_ready = (state==RUN) & slot free.
- out_valid rises on the edge after the producing step and holds, with out_data stable, until out_ready is seen high.
- Simultaneous output accept and new step: the slot reloads on the same edge, so there is no bubble. Throughput is 1 pixel/cycle with both sides continuously ready.
- Latency: output k becomes valid 1 cycle after the step that accepts input k+IMG_W+1, or the equivalent flush step.
- frame_done is high for exactly 1 cycle, the cycle after the final output handshake.
- Reset values: in_ready 0 during the rst cycle, 1 afterwards. out_valid 0, out_data 0, frame_done 0, state RUN.

## Test plan
- Erosion, IMG_W=4, IMG_H=3, THRESH=127, all inputs 200, both sides always ready → 12 outputs of 255 with no border erosion; frame_done pulses once, one cycle after the 12th output.
- Erosion, same size, all 200 except pixel (1,1)=100 → outputs at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(2,0),(2,1),(2,2) are 0; column 3 is 255.
- Dilation, all 0 except (0,0)=128 → outputs (0,0),(0,1),(1,0),(1,1) are 255, all others 0. Confirms that 128 > 127 counts as foreground and 127 does not.
- Backpressure: random out_ready (50%) and random in_valid → output sequence identical to the unstalled run; out_data never changes while out_valid & !out_ready.
- Mode latch: toggle mode mid-frame → the whole frame uses the mode sampled at pixel (0,0). A second frame issued back-to-back with the other mode → correct per-frame mode.
- Reset after 7 pixels of a frame → out_valid 0 the next cycle. A following full all-200 erosion frame → 12 outputs of 255 and exactly one frame_done.

Source files
------------

// File: rtl/morph3x3_stream_if.sv
// Pixel stream bundle for morph3x3_stream: input and output valid/ready
// channels, the per-frame mode select and the end-of-frame pulse.
interface morph3x3_stream_if #(
    parameter int DATA_W = 8
);
    logic              mode;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              frame_done;

    modport master (
        output mode,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  frame_done
    );

    modport slave (
        input  mode,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output frame_done
    );
endinterface

// File: rtl/morph3x3_stream.sv
// Streaming 3x3 binary erosion/dilation over raster-order pixels, thresholded
// to one bit, with self-flushing of the final line and a single output slot.
module morph3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int THRESH = 127
) (
    input  logic             clk,
    input  logic             rst,
    morph3x3_stream_if.slave bus
);
    localparam int CW  = $clog2(IMG_W);
    localparam int IRW = $clog2(IMG_H + 2);
    localparam int ORW = $clog2(IMG_H);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0]     COL_LAST     = CW'(IMG_W - 1);
    localparam logic [IRW-1:0]    IN_ROW_LAST  = IRW'(IMG_H - 1);
    localparam logic [IRW-1:0]    IN_ROW_ONE   = IRW'(1);
    localparam logic [ORW-1:0]    OUT_ROW_LAST = ORW'(IMG_H - 1);
    localparam logic [DATA_W-1:0] THRESH_V     = DATA_W'(THRESH);

    function automatic logic thresh_bit(input logic [DATA_W-1:0] d);
        return d > THRESH_V;
    endfunction

    // Masked taps take the neutral value: 1 for AND (erosion), 0 for OR (dilation).
    function automatic logic morph_eval(input logic [8:0] win,
                                        input logic [8:0] msk,
                                        input logic       dil);
        if (dil)
            return |(win & ~msk);
        return &(win | msk);
    endfunction

    logic [1:0]       state;
    logic [CW-1:0]    in_col;
    logic [IRW-1:0]   in_row;
    logic [CW-1:0]    out_col;
    logic [ORW-1:0]   out_row;
    logic             mode_q;
    logic             last_emitted;

    logic [IMG_W-1:0] lb0;
    logic [IMG_W-1:0] lb1;
    logic [2:0]       win_l;
    logic [2:0]       win_c;

    logic             slot_free;
    logic             in_ready_c;
    logic             step_p0;
    logic             emit_p0;
    logic             bit_p0;
    logic             last_in_p0;
    logic [2:0]       col_n_p0;
    logic [8:0]       win_p0;
    logic [8:0]       msk_p0;
    logic             res_p0;
    logic             top_m;
    logic             bot_m;
    logic             lft_m;
    logic             rgt_m;

    logic             vld_p1;
    logic [DATA_W-1:0] data_p1;

    // Stage p0: step decode, threshold, window assembly and border masking
    assign slot_free  = !vld_p1 || bus.out_ready;
    assign in_ready_c = !rst && (state == ST_RUN) && slot_free;

    always_comb begin
        step_p0 = 1'b0;
        case (state)
            ST_RUN:   step_p0 = bus.in_valid && in_ready_c;
            ST_FLUSH: step_p0 = slot_free && !last_emitted;
            default:  step_p0 = 1'b0;
        endcase
    end

    assign bit_p0     = (state == ST_RUN) && thresh_bit(bus.in_data);
    assign last_in_p0 = (in_row == IN_ROW_LAST) && (in_col == COL_LAST);

    // The first IMG_W+1 steps of a frame only fill the window.
    assign emit_p0 = step_p0 &&
                     ((state == ST_FLUSH) ||
                      (in_row > IN_ROW_ONE) ||
                      ((in_row == IN_ROW_ONE) && (in_col != '0)));

    assign col_n_p0 = {bit_p0, lb0[in_col], lb1[in_col]};

    assign win_p0 = {col_n_p0[2], win_c[2], win_l[2],
                     col_n_p0[1], win_c[1], win_l[1],
                     col_n_p0[0], win_c[0], win_l[0]};

    assign top_m = (out_row == '0);
    assign bot_m = (out_row == OUT_ROW_LAST);
    assign lft_m = (out_col == '0);
    assign rgt_m = (out_col == COL_LAST);

    assign msk_p0 = {bot_m | rgt_m, bot_m, bot_m | lft_m,
                     rgt_m,         1'b0,  lft_m,
                     top_m | rgt_m, top_m, top_m | lft_m};

    assign res_p0 = morph_eval(win_p0, msk_p0, mode_q);

    // Line buffers and window columns hold pixel bits only and are never cleared;
    // anything stale is outside the image and gets masked.
    always_ff @(posedge clk) begin
        if (step_p0) begin
            lb1[in_col] <= lb0[in_col];
            lb0[in_col] <= bit_p0;
            win_l       <= win_c;
            win_c       <= col_n_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            in_col       <= '0;
            in_row       <= '0;
            out_col      <= '0;
            out_row      <= '0;
            mode_q       <= 1'b0;
            last_emitted <= 1'b0;
            vld_p1       <= 1'b0;
            data_p1      <= '0;
        end else begin
            if (step_p0) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end

            if (step_p0 && (state == ST_RUN) && (in_col == '0) && (in_row == '0))
                mode_q <= bus.mode;

            if (emit_p0) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == OUT_ROW_LAST) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
                if ((out_col == COL_LAST) && (out_row == OUT_ROW_LAST))
                    last_emitted <= 1'b1;
            end

            // Stage p1: single output slot, reloads on the same edge it drains
            if (emit_p0) begin
                vld_p1  <= 1'b1;
                data_p1 <= {DATA_W{res_p0}};
            end else if (bus.out_ready) begin
                vld_p1  <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (step_p0 && last_in_p0)
                        state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (last_emitted && vld_p1 && bus.out_ready)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    state        <= ST_RUN;
                    in_col       <= '0;
                    in_row       <= '0;
                    out_col      <= '0;
                    out_row      <= '0;
                    last_emitted <= 1'b0;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = data_p1;
    assign bus.frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_morph3x3_stream.sv
// Directed bench for morph3x3_stream on a 4x3 image with hand-computed outputs.
module tb_morph3x3_stream;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    morph3x3_stream_if #(.DATA_W(8)) bus ();

    morph3x3_stream #(
        .DATA_W(8),
        .IMG_W (4),
        .IMG_H (3),
        .THRESH(127)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] pix  [0:23];
    logic       mseq [0:23];
    logic [7:0] got  [0:23];
    int done_cnt, stall_bad, out_cnt, last_out_cyc, done_cyc;

    // Drives npix pixels and collects outputs, one decision per cycle at negedge.
    task automatic run_stream(input int npix, input int nexp, input bit rin,
                              input bit rout, output bit tmo);
        int ip, op, cyc, tail;
        bit stall_prev;
        logic [7:0] d_prev;
        ip = 0; op = 0; cyc = 0; tail = 0; stall_prev = 1'b0; d_prev = '0;
        done_cnt = 0; stall_bad = 0; last_out_cyc = -1; done_cyc = -1;
        while (tail < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stall_prev && (bus.out_valid !== 1'b1 || bus.out_data !== d_prev))
                stall_bad++;
            if (bus.frame_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            bus.in_valid  = (ip < npix) && (!rin || ($urandom_range(0, 1) == 1));
            bus.in_data   = pix[(ip < npix) ? ip : npix - 1];
            bus.mode      = mseq[(ip < npix) ? ip : npix - 1];
            bus.out_ready = !rout || ($urandom_range(0, 1) == 1);
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (op < 24) got[op] = bus.out_data;
                op++;
                last_out_cyc = cyc;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) ip++;
            stall_prev = (bus.out_valid === 1'b1) && !bus.out_ready;
            d_prev = bus.out_data;
            if (op >= nexp) tail++;
        end
        out_cnt = op;
        tmo = (tail < 3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", bus.out_data); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_erode_solid();
        bit tmo;
        for (int i = 0; i < 12; i++) begin pix[i] = 8'd200; mseq[i] = 1'b0; end
        run_stream(12, 12, 1'b0, 1'b0, tmo);
        total++; if (tmo) begin bad++; $display("FAIL solid_timeout got=%0d outputs want=12", out_cnt); end
        total++; if (out_cnt != 12) begin bad++; $display("FAIL solid_count got=%0d want=12", out_cnt); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got[i] !== 8'd255) begin bad++; $display("FAIL solid_out[%0d] got=%0d want=255", i, got[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL solid_done_cnt got=%0d want=1", done_cnt); end
        total++; if (done_cyc - last_out_cyc != 1) begin bad++; $display("FAIL solid_done_gap got=%0d want=1", done_cyc - last_out_cyc); end
    endtask

    task automatic test_erode_hole();
        bit tmo;
        logic [7:0] e [0:11];
        e = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
        for (int i = 0; i < 12; i++) begin pix[i] = 8'd200; mseq[i] = 1'b0; end
        pix[5] = 8'd100;
        run_stream(12, 12, 1'b0, 1'b0, tmo);
        total++; if (tmo || out_cnt != 12) begin bad++; $display("FAIL hole_count got=%0d want=12", out_cnt); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got[i] !== e[i]) begin bad++; $display("FAIL hole_out[%0d] got=%0d want=%0d", i, got[i], e[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL hole_done_cnt got=%0d want=1", done_cnt); end
    endtask

    task automatic test_dilate_point();
        bit tmo;
        logic [7:0] e [0:11];
        e = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 12; i++) begin pix[i] = 8'd0; mseq[i] = 1'b1; end
        pix[0] = 8'd128;
        run_stream(12, 12, 1'b0, 1'b0, tmo);
        total++; if (tmo || out_cnt != 12) begin bad++; $display("FAIL dil128_count got=%0d want=12", out_cnt); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got[i] !== e[i]) begin bad++; $display("FAIL dil128_out[%0d] got=%0d want=%0d", i, got[i], e[i]); end
        end
        pix[0] = 8'd127;
        run_stream(12, 12, 1'b0, 1'b0, tmo);
        total++; if (tmo || out_cnt != 12) begin bad++; $display("FAIL dil127_count got=%0d want=12", out_cnt); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got[i] !== 8'd0) begin bad++; $display("FAIL dil127_out[%0d] got=%0d want=0", i, got[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit tmo;
        logic [7:0] e [0:11];
        e = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
        for (int i = 0; i < 12; i++) begin pix[i] = 8'd200; mseq[i] = 1'b0; end
        pix[5] = 8'd100;
        run_stream(12, 12, 1'b1, 1'b1, tmo);
        total++; if (tmo || out_cnt != 12) begin bad++; $display("FAIL bp_count got=%0d want=12", out_cnt); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got[i] !== e[i]) begin bad++; $display("FAIL bp_out[%0d] got=%0d want=%0d", i, got[i], e[i]); end
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d changes want=0", stall_bad); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt got=%0d want=1", done_cnt); end
    endtask

    task automatic test_back_to_back_mode();
        bit tmo;
        logic [7:0] e [0:23];
        e = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255,
              8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 12; i++) begin
            pix[i]       = (i == 5) ? 8'd100 : 8'd200;
            pix[i + 12]  = (i == 0) ? 8'd128 : 8'd0;
            mseq[i]      = i[0];
            mseq[i + 12] = ~i[0];
        end
        run_stream(24, 24, 1'b0, 1'b0, tmo);
        total++; if (tmo || out_cnt != 24) begin bad++; $display("FAIL b2b_count got=%0d want=24", out_cnt); end
        for (int i = 0; i < 24; i++) begin
            total++;
            if (got[i] !== e[i]) begin bad++; $display("FAIL b2b_out[%0d] got=%0d want=%0d", i, got[i], e[i]); end
        end
        total++; if (done_cnt != 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d want=2", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        bus.out_ready = 1'b1;
        bus.mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'd200;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", bus.out_valid); end
        rst = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=0", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_post_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'd0) begin bad++; $display("FAIL mid_post_data got=%0d want=0", bus.out_data); end
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_post_in_ready got=%b want=1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin pix[i] = 8'd200; mseq[i] = 1'b0; end
        run_stream(12, 12, 1'b0, 1'b0, tmo);
        total++; if (tmo || out_cnt != 12) begin bad++; $display("FAIL mid_count got=%0d want=12", out_cnt); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got[i] !== 8'd255) begin bad++; $display("FAIL mid_out[%0d] got=%0d want=255", i, got[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL mid_done_cnt got=%0d want=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_erode_solid();
        test_erode_hole();
        test_dilate_point();
        test_backpressure();
        test_back_to_back_mode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
